addr_route_decoder: RTL and testbench

ADDR_ROUTE_DECODER -- requirements
Module: addr_route_decoder

---
 rtl/addr_route_decoder_pkg.sv | 96 +++++++++
 rtl/addr_route_decode_comb.sv | 79 +++++++
 rtl/addr_route_decoder.sv | 103 ++++++++++
 tb/tb_addr_route_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_route_decoder_pkg.sv
// Shared address package: request address layout, routing destinations and
// the decoded-route bundle passed from the decode logic to the pipeline.
`timescale 1ns/1ps
package addr_route_decoder_pkg;

    localparam int ADDR_W       = 27;
    localparam int RACK_ID_W    = 3;
    localparam int DEST_E_WIDTH = 4;
    localparam int OFFSET_W     = 23;

    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [RACK_ID_W-1:0] rack_id_t;

    typedef enum logic {NON_ZAP = 1'b0, ZAP = 1'b1} IS_ZAP_E;
    typedef enum logic {MEM = 1'b0, CSR = 1'b1} IS_CSR_E;

    typedef enum logic [3:0] {
        ZB_NONE  = 4'd0,
        ZB_BLK1  = 4'd1,  ZB_BLK2  = 4'd2,  ZB_BLK3  = 4'd3,  ZB_BLK4  = 4'd4,
        ZB_BLK5  = 4'd5,  ZB_BLK6  = 4'd6,  ZB_BLK7  = 4'd7,  ZB_BLK8  = 4'd8,
        ZB_BLK9  = 4'd9,  ZB_BLK10 = 4'd10, ZB_BLK11 = 4'd11, ZB_BLK12 = 4'd12
    } ZAP_BLOCK_ID_E;

    typedef enum logic [2:0] {
        NZ_LEG     = 3'd0,
        NZ_TAX     = 3'd1,
        NZ_EGO     = 3'd2,
        NZ_RSVD    = 3'd3,
        NZ_ASH     = 3'd4,
        NZ_SIN     = 3'd5,
        NZ_RACK_ID = 3'd6,
        NZ_FOX     = 3'd7
    } NON_ZAP_BLOCK_ID_E;

    typedef enum logic [1:0] {
        RB_ICE  = 2'd0,
        RB_CRY  = 2'd1,
        RB_CUP  = 2'd2,
        RB_RSVD = 2'd3
    } RACK_BLOCK_ID_E;

    typedef enum logic [DEST_E_WIDTH-1:0] {
        DEST_ERR     = 4'd0,
        DEST_ZAP_MEM = 4'd1,
        DEST_ZAP_CSR = 4'd2,
        DEST_LEG     = 4'd3,
        DEST_TAX     = 4'd4,
        DEST_EGO     = 4'd5,
        DEST_ASH     = 4'd6,
        DEST_SIN     = 4'd7,
        DEST_FOX     = 4'd8,
        DEST_ICE     = 4'd9,
        DEST_CRY     = 4'd10,
        DEST_CUP     = 4'd11,
        DEST_UPLINK  = 4'd12
    } DEST_E;

    // Zap view of the address; job_addr is either a memory offset or a CSR job.
    typedef struct packed {
        IS_ZAP_E     is_zap;
        IS_CSR_E     is_csr;
        rack_id_t    rack_id;
        logic [2:0]  zap_id;
        logic [18:0] job_addr;
    } zap_addr_t;

    typedef struct packed {
        ZAP_BLOCK_ID_E zap_block_id;
        logic [14:0]   offset;
    } zap_csr_job_t;

    typedef struct packed {
        IS_ZAP_E           is_zap;
        NON_ZAP_BLOCK_ID_E non_zap_block_id;
        logic [22:0]       sub_addr;
    } non_zap_addr_t;

    typedef struct packed {
        rack_id_t       rack_id;
        RACK_BLOCK_ID_E rack_block_id;
        logic [2:0]     rack_block_inst_id;
        logic [14:0]    offset;
    } rack_sub_addr_t;

    typedef struct packed {
        DEST_E                dest;
        logic [2:0]           inst;
        ZAP_BLOCK_ID_E        sub_id;
        logic [OFFSET_W-1:0]  offset;
    } route_t;

    function automatic logic zap_csr_block_legal(input ZAP_BLOCK_ID_E id);
        return (id >= ZB_BLK1) && (id <= ZB_BLK12);
    endfunction

endpackage

// File: rtl/addr_route_decode_comb.sv
// Pure-combinational address decode: maps a request address and the local
// rack ID onto a destination, instance, CSR sub-block and local offset.
`timescale 1ns/1ps
module addr_route_decode_comb
    import addr_route_decoder_pkg::*;
(
    input  addr_t    i_addr,
    input  rack_id_t i_rack_id,
    output route_t   o_route
);

    zap_addr_t      w_zap;
    zap_csr_job_t   w_csr;
    non_zap_addr_t  w_nz;
    rack_sub_addr_t w_rack;

    assign w_zap  = zap_addr_t'(i_addr);
    assign w_csr  = zap_csr_job_t'(w_zap.job_addr);
    assign w_nz   = non_zap_addr_t'(i_addr);
    assign w_rack = rack_sub_addr_t'(w_nz.sub_addr);

    always_comb begin
        // NOTE: defaulting the whole route first keeps every path assigned, so no latch is inferred.
        o_route      = '0;
        o_route.dest = DEST_ERR;

        if (w_nz.is_zap == ZAP) begin
            if (w_zap.rack_id != i_rack_id) begin
                o_route.dest = DEST_UPLINK;
            end else if (w_zap.is_csr == MEM) begin
                o_route.dest   = DEST_ZAP_MEM;
                o_route.inst   = w_zap.zap_id;
                o_route.offset = {4'b0, w_zap.job_addr};
            end else if (zap_csr_block_legal(w_csr.zap_block_id)) begin
                o_route.dest   = DEST_ZAP_CSR;
                o_route.inst   = w_zap.zap_id;
                o_route.sub_id = w_csr.zap_block_id;
                o_route.offset = {8'b0, w_csr.offset};
            end
        end else begin
            case (w_nz.non_zap_block_id)
                NZ_LEG: begin o_route.dest = DEST_LEG; o_route.offset = w_nz.sub_addr; end
                NZ_TAX: begin o_route.dest = DEST_TAX; o_route.offset = w_nz.sub_addr; end
                NZ_EGO: begin o_route.dest = DEST_EGO; o_route.offset = w_nz.sub_addr; end
                NZ_ASH: begin o_route.dest = DEST_ASH; o_route.offset = w_nz.sub_addr; end
                NZ_SIN: begin o_route.dest = DEST_SIN; o_route.offset = w_nz.sub_addr; end
                NZ_FOX: begin o_route.dest = DEST_FOX; o_route.offset = w_nz.sub_addr; end
                NZ_RACK_ID: begin
                    // Foreign-rack traffic is forwarded untouched; field checks belong to that rack.
                    if (w_rack.rack_id != i_rack_id) begin
                        o_route.dest = DEST_UPLINK;
                    end else begin
                        case (w_rack.rack_block_id)
                            RB_ICE: begin
                                if (w_rack.rack_block_inst_id == 3'd0) begin
                                    o_route.dest   = DEST_ICE;
                                    o_route.offset = {8'b0, w_rack.offset};
                                end
                            end
                            RB_CRY: begin
                                o_route.dest   = DEST_CRY;
                                o_route.inst   = w_rack.rack_block_inst_id;
                                o_route.offset = {8'b0, w_rack.offset};
                            end
                            RB_CUP: begin
                                o_route.dest   = DEST_CUP;
                                o_route.inst   = w_rack.rack_block_inst_id;
                                o_route.offset = {8'b0, w_rack.offset};
                            end
                            default: o_route.dest = DEST_ERR;
                        endcase
                    end
                end
                default: o_route.dest = DEST_ERR;
            endcase
        end
    end

endmodule

// File: rtl/addr_route_decoder.sv
// One-deep valid/ready pipeline around the address decode, plus a saturating
// decode-error counter and a sticky first-error address capture.
`timescale 1ns/1ps
module addr_route_decoder
    import addr_route_decoder_pkg::*;
#(
    parameter int ERR_CNT_W = 16
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  rack_id_t             i_rack_id,
    input  logic                 i_vld,
    output logic                 o_rdy,
    input  addr_t                i_addr,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output addr_t                o_addr,
    output DEST_E                o_dest,
    output logic [2:0]           o_inst,
    output ZAP_BLOCK_ID_E        o_sub_id,
    output logic [OFFSET_W-1:0]  o_offset,
    output logic                 o_err,
    input  logic                 i_err_clr,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_first_err_vld,
    output addr_t                o_first_err_addr
);

    route_t                w_route;
    logic                  w_load;
    logic                  w_err_load;

    logic                  r_vld;
    addr_t                 r_addr;
    route_t                r_route;
    logic                  r_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  r_first_err_vld;
    addr_t                 r_first_err_addr;

    addr_route_decode_comb u_decode (
        .i_addr    (i_addr),
        .i_rack_id (i_rack_id),
        .o_route   (w_route)
    );

    assign o_rdy      = !r_vld || i_rdy;
    assign w_load     = i_vld && o_rdy;
    assign w_err_load = w_load && (w_route.dest == DEST_ERR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_addr  <= '0;
            r_route <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_vld   <= 1'b1;
            r_addr  <= i_addr;
            r_route <= w_route;
            r_err   <= (w_route.dest == DEST_ERR);
        end else if (i_rdy) begin
            r_vld   <= 1'b0;
        end
    end

    // A clear coinciding with an error load restarts the statistics from that error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt        <= '0;
            r_first_err_vld  <= 1'b0;
            r_first_err_addr <= '0;
        end else if (i_err_clr) begin
            r_err_cnt       <= w_err_load ? ERR_CNT_W'(1) : '0;
            r_first_err_vld <= w_err_load;
            if (w_err_load) begin
                r_first_err_addr <= i_addr;
            end
        end else if (w_err_load) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
            if (!r_first_err_vld) begin
                r_first_err_vld  <= 1'b1;
                r_first_err_addr <= i_addr;
            end
        end
    end

    assign o_vld            = r_vld;
    assign o_addr           = r_addr;
    assign o_dest           = r_route.dest;
    assign o_inst           = r_route.inst;
    assign o_sub_id         = r_route.sub_id;
    assign o_offset         = r_route.offset;
    assign o_err            = r_err;
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_vld  = r_first_err_vld;
    assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_addr_route_decoder.sv
// Scoreboard bench for addr_route_decoder: a driver pushes model results on
// each accepted request, a negedge monitor compares every presented result.
`timescale 1ns/1ps
module tb_addr_route_decoder;
    import addr_route_decoder_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    rack_id_t          i_rack_id;
    logic              i_vld;
    logic              o_rdy;
    addr_t             i_addr;
    logic              o_vld;
    logic              i_rdy;
    addr_t             o_addr;
    DEST_E             o_dest;
    logic [2:0]        o_inst;
    ZAP_BLOCK_ID_E     o_sub_id;
    logic [22:0]       o_offset;
    logic              o_err;
    logic              i_err_clr;
    logic [CNT_W-1:0]  o_err_cnt;
    logic              o_first_err_vld;
    addr_t             o_first_err_addr;

    addr_route_decoder #(.ERR_CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_rack_id        (i_rack_id),
        .i_vld            (i_vld),
        .o_rdy            (o_rdy),
        .i_addr           (i_addr),
        .o_vld            (o_vld),
        .i_rdy            (i_rdy),
        .o_addr           (o_addr),
        .o_dest           (o_dest),
        .o_inst           (o_inst),
        .o_sub_id         (o_sub_id),
        .o_offset         (o_offset),
        .o_err            (o_err),
        .i_err_clr        (i_err_clr),
        .o_err_cnt        (o_err_cnt),
        .o_first_err_vld  (o_first_err_vld),
        .o_first_err_addr (o_first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] addr;
        int          dest;
        int          inst;
        int          sub;
        int          offset;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          pushed = 0;
    int          popped = 0;
    int          cnt_m  = 0;
    bit          fv_m   = 0;
    logic [26:0] fa_m   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference routing written directly from the address field rules.
    function automatic exp_t model(input logic [26:0] a, input logic [2:0] rack);
        exp_t e;
        int   nz, rb, blk;
        e.addr = a; e.dest = 0; e.inst = 0; e.sub = 0; e.offset = 0;
        if (a[26]) begin
            blk = int'(a[18:15]);
            if (a[24:22] != rack) e.dest = 12;
            else if (!a[25]) begin
                e.dest = 1; e.inst = int'(a[21:19]); e.offset = int'(a[18:0]);
            end else if (blk >= 1 && blk <= 12) begin
                e.dest = 2; e.inst = int'(a[21:19]); e.sub = blk; e.offset = int'(a[14:0]);
            end
        end else begin
            nz = int'(a[25:23]);
            case (nz)
                0: e.dest = 3;
                1: e.dest = 4;
                2: e.dest = 5;
                4: e.dest = 6;
                5: e.dest = 7;
                7: e.dest = 8;
                default: e.dest = 0;
            endcase
            if (e.dest != 0) e.offset = int'(a[22:0]);
            if (nz == 6) begin
                rb = int'(a[19:18]);
                if (a[22:20] != rack) e.dest = 12;
                else if (rb == 0 && a[17:15] == 3'd0) begin e.dest = 9; e.offset = int'(a[14:0]); end
                else if (rb == 1 || rb == 2) begin
                    e.dest = 9 + rb; e.inst = int'(a[17:15]); e.offset = int'(a[14:0]);
                end
            end
        end
        e.err = (e.dest == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("o_rdy_rule", 64'(o_rdy), 64'(!o_vld || i_rdy));
            if (o_vld) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got addr 0x%0h expected no result", o_addr);
                end else begin
                    mon_e = sb[0];
                    check("o_addr",   64'(o_addr),   64'(mon_e.addr));
                    check("o_dest",   64'(o_dest),   64'(mon_e.dest));
                    check("o_inst",   64'(o_inst),   64'(mon_e.inst));
                    check("o_sub_id", 64'(o_sub_id), 64'(mon_e.sub));
                    check("o_offset", 64'(o_offset), 64'(mon_e.offset));
                    check("o_err",    64'(o_err),    64'(mon_e.err));
                    if (i_rdy) begin
                        void'(sb.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [26:0] a, input bit clr);
        exp_t e;
        bit   ok = 0;
        i_vld = 1'b1; i_addr = a; i_err_clr = clr;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_rdy) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got o_rdy 0 for 200 cycles expected 1");
        end else begin
            e = model(a, i_rack_id);
            sb.push_back(e);
            pushed++;
            if (clr) begin
                cnt_m = e.err ? 1 : 0;
                fv_m  = e.err;
                if (e.err) fa_m = a;
            end else if (e.err) begin
                if (cnt_m < CNT_MAX) cnt_m++;
                if (!fv_m) begin fv_m = 1; fa_m = a; end
            end
        end
        @(posedge clk); #1;
        i_vld = 1'b0; i_err_clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin tick(1); n++; end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(cnt_m));
        check({tag, "_first_vld"}, 64'(o_first_err_vld), 64'(fv_m));
        if (fv_m) check({tag, "_first_addr"}, 64'(o_first_err_addr), 64'(fa_m));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vld"},  64'(o_vld), 64'd0);
        check({tag, "_addr"}, 64'(o_addr), 64'd0);
        check({tag, "_dest"}, 64'(o_dest), 64'd0);
        check({tag, "_inst"}, 64'(o_inst), 64'd0);
        check({tag, "_sub"},  64'(o_sub_id), 64'd0);
        check({tag, "_off"},  64'(o_offset), 64'd0);
        check({tag, "_err"},  64'(o_err), 64'd0);
        check({tag, "_cnt"},  64'(o_err_cnt), 64'd0);
        check({tag, "_fv"},   64'(o_first_err_vld), 64'd0);
        check({tag, "_fa"},   64'(o_first_err_addr), 64'd0);
    endtask

    function automatic logic [26:0] rand_addr(input logic [2:0] rack);
        logic [26:0] a;
        a = 27'($urandom);
        if (!a[26] && $urandom_range(0, 2) == 0) a[25:23] = 3'd6;
        if ($urandom_range(0, 3) != 0) begin
            if (a[26]) a[24:22] = rack;
            else       a[22:20] = rack;
        end
        return a;
    endfunction

    initial begin
        bit done;
        rst_n = 1'b0; i_rack_id = 3'd2; i_vld = 1'b0; i_addr = '0;
        i_rdy = 1'b1; i_err_clr = 1'b0;
        tick(3);
        check_reset_vals("reset");
        check("reset_rdy", 64'(o_rdy), 64'd1);
        rst_n = 1'b1;
        tick(1);

        // Directed vectors with one-cycle latency checks.
        send(27'h4A80123, 0);
        check("lat_vld", 64'(o_vld), 64'd1);
        check("lat_dest_zap_mem", 64'(o_dest), 64'd1);
        tick(1);
        check("vld_drop", 64'(o_vld), 64'd0);
        send(27'h6A80000, 0);
        tick(1);
        check_stats("csr_blk0");
        check("csr_blk0_cnt_abs", 64'(o_err_cnt), 64'd1);

        i_err_clr = 1'b1; tick(1); i_err_clr = 1'b0;
        cnt_m = 0; fv_m = 0;
        check_stats("clr");
        send(27'h1800000, 0);
        send(27'h3208000, 0);
        tick(1);
        check_stats("two_err");
        check("two_err_first", 64'(o_first_err_addr), 64'h1800000);
        send(27'h34B8010, 0);
        send(27'h4A0A123, 0);
        send(27'h6A9C005, 0);
        send(27'h0B12345, 0);
        send(27'h3214ABC, 0);
        drain();

        // Back-to-back stream with a 3-cycle output stall.
        fork
            begin
                send(27'h4A80001, 0); send(27'h6A88002, 0);
                send(27'h0400003, 0); send(27'h3228004, 0);
                send(27'h1800005, 0); send(27'h34B8006, 0);
            end
            begin
                tick(2);
                i_rdy = 1'b0;
                @(negedge clk);
                check("stall_rdy_low", 64'(o_rdy), 64'd0);
                tick(3);
                i_rdy = 1'b1;
            end
        join
        drain();
        check("stream_no_loss", 64'(popped), 64'(pushed));
        check_stats("stream");

        // Randomized traffic with random back-pressure, two rack IDs.
        for (int phase = 0; phase < 2; phase++) begin
            i_rack_id = (phase == 0) ? 3'd2 : 3'd5;
            done = 0;
            fork
                begin
                    for (int k = 0; k < 150; k++) begin
                        send(rand_addr(i_rack_id), 0);
                        if ($urandom_range(0, 3) == 0) tick(1);
                    end
                    done = 1;
                end
                begin
                    while (!done) begin
                        tick(1);
                        i_rdy = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            i_rdy = 1'b1;
            drain();
            check_stats("random");
        end
        check("random_no_loss", 64'(popped), 64'(pushed));

        // Saturation, then clear coinciding with a fresh error.
        i_rack_id = 3'd2;
        i_err_clr = 1'b1; tick(1); i_err_clr = 1'b0;
        cnt_m = 0; fv_m = 0;
        for (int k = 0; k < CNT_MAX + 3; k++) send(27'h1800000, 0);
        drain();
        check_stats("saturate");
        check("saturate_abs", 64'(o_err_cnt), 64'(CNT_MAX));
        send(27'h3208000, 1);
        drain();
        check_stats("clr_coincide");
        check("clr_coincide_abs", 64'(o_err_cnt), 64'd1);

        // Reset asserted while a result is stalled.
        i_rdy = 1'b0;
        send(27'h4A80123, 0);
        tick(1);
        check("pre_reset_vld", 64'(o_vld), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_reset");
        sb.delete();
        cnt_m = 0; fv_m = 0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("post_reset_rdy", 64'(o_rdy), 64'd1);
        check("post_reset_vld", 64'(o_vld), 64'd0);
        i_rdy = 1'b1;
        send(27'h2000010, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
